// File: rtl/biriscv_mule_iter.sv
// Iterative shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Consumes BITS_PER_CYCLE multiplier bits per RUN cycle and returns one registered result.
module biriscv_mule_iter #(
   parameter int unsigned BITS_PER_CYCLE = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        opcode_valid_i,
   input  logic [31:0] opcode_opcode_i,
   input  logic [4:0]  opcode_rd_idx_i,
   input  logic [31:0] opcode_ra_operand_i,
   input  logic [31:0] opcode_rb_operand_i,
   input  logic        hold_i,
   input  logic        flush_i,
   output logic        stall_o,
   output logic        mule_complete_o,
   output logic [31:0] mule_result_o,
   output logic [4:0]  mule_rd_idx_o
);

   localparam int unsigned ITER     = 32 / BITS_PER_CYCLE;
   localparam logic [5:0]  LAST_CNT = 6'(ITER - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e      state_q;
   logic [5:0]  cnt_q;
   logic [63:0] acc_q;
   logic [63:0] a_q;
   logic [31:0] b_q;
   logic        neg_q;
   logic [1:0]  op_q;
   logic [4:0]  rd_q;
   logic        complete_q;
   logic [31:0] result_q;
   logic [4:0]  rd_out_q;

   logic        is_mul;
   logic        accept;
   logic [1:0]  funct;
   logic        sign_a;
   logic        sign_b;
   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic [63:0] partial;
   logic [63:0] acc_next;
   logic [63:0] prod;
   logic [31:0] prod_word;
   logic        unused_opcode_bits;

   assign is_mul = opcode_valid_i && (opcode_opcode_i[6:0] == 7'b0110011) &&
                   (opcode_opcode_i[31:25] == 7'b0000001) && !opcode_opcode_i[14];
   assign funct  = opcode_opcode_i[13:12];
   assign accept = is_mul && (state_q == StIdle) && !hold_i && !flush_i;

   // rs1 signed except MULHU; rs2 signed only for MUL and MULH.
   assign sign_a = (funct != 2'b11) && opcode_ra_operand_i[31];
   assign sign_b = !funct[1] && opcode_rb_operand_i[31];
   assign mag_a  = sign_a ? (~opcode_ra_operand_i + 32'd1) : opcode_ra_operand_i;
   assign mag_b  = sign_b ? (~opcode_rb_operand_i + 32'd1) : opcode_rb_operand_i;

   assign unused_opcode_bits = ^{opcode_opcode_i[24:15], opcode_opcode_i[11:7]};

   always_comb begin
      partial = '0;
      for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
         if (b_q[i]) partial = partial + (a_q << i);
      end
      acc_next  = acc_q + partial;
      prod      = neg_q ? (~acc_next + 64'd1) : acc_next;
      prod_word = (op_q == 2'b00) ? prod[31:0] : prod[63:32];
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         acc_q      <= '0;
         a_q        <= '0;
         b_q        <= '0;
         neg_q      <= 1'b0;
         op_q       <= '0;
         rd_q       <= '0;
         complete_q <= 1'b0;
         result_q   <= '0;
         rd_out_q   <= '0;
      end else if (flush_i) begin
         state_q    <= StIdle;
         complete_q <= 1'b0;
      end else if (!hold_i) begin
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  rd_q  <= opcode_rd_idx_i;
                  op_q  <= funct;
                  neg_q <= sign_a ^ sign_b;
                  a_q   <= {32'd0, mag_a};
                  b_q   <= mag_b;
                  acc_q <= '0;
                  cnt_q <= '0;
                  if ((opcode_ra_operand_i == 32'd0) || (opcode_rb_operand_i == 32'd0)) begin
                     state_q    <= StDone;
                     complete_q <= 1'b1;
                     result_q   <= '0;
                     rd_out_q   <= opcode_rd_idx_i;
                  end else begin
                     state_q <= StRun;
                  end
               end
            end
            StRun: begin
               acc_q <= acc_next;
               a_q   <= a_q << BITS_PER_CYCLE;
               b_q   <= b_q >> BITS_PER_CYCLE;
               cnt_q <= cnt_q + 6'd1;
               // Outputs are captured from the final accumulation on entry to DONE.
               if (cnt_q == LAST_CNT) begin
                  state_q    <= StDone;
                  complete_q <= 1'b1;
                  result_q   <= prod_word;
                  rd_out_q   <= rd_q;
               end
            end
            StDone: begin
               state_q    <= StIdle;
               complete_q <= 1'b0;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign stall_o         = (state_q != StIdle) || accept;
   assign mule_complete_o = complete_q;
   assign mule_result_o   = result_q;
   assign mule_rd_idx_o   = rd_out_q;

endmodule

// File: tb/tb_biriscv_mule_iter.sv
// Scoreboard bench for biriscv_mule_iter: stimulus pushes expected completions,
// a negedge monitor pops and compares whenever mule_complete_o is high.
module tb_biriscv_mule_iter;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        opcode_valid_i = 1'b0;
   logic [31:0] opcode_opcode_i = '0;
   logic [4:0]  opcode_rd_idx_i = '0;
   logic [31:0] opcode_ra_operand_i = '0;
   logic [31:0] opcode_rb_operand_i = '0;
   logic        hold_i = 1'b0;
   logic        flush_i = 1'b0;
   logic        stall_o;
   logic        mule_complete_o;
   logic [31:0] mule_result_o;
   logic [4:0]  mule_rd_idx_o;

   biriscv_mule_iter #(.BITS_PER_CYCLE(2)) dut (
      .clk_i               (clk_i),
      .rst_i               (rst_i),
      .opcode_valid_i      (opcode_valid_i),
      .opcode_opcode_i     (opcode_opcode_i),
      .opcode_rd_idx_i     (opcode_rd_idx_i),
      .opcode_ra_operand_i (opcode_ra_operand_i),
      .opcode_rb_operand_i (opcode_rb_operand_i),
      .hold_i              (hold_i),
      .flush_i             (flush_i),
      .stall_o             (stall_o),
      .mule_complete_o     (mule_complete_o),
      .mule_result_o       (mule_result_o),
      .mule_rd_idx_o       (mule_rd_idx_o)
   );

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      logic [31:0] res;
      logic [4:0]  rd;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   localparam logic [1:0] F_MUL = 2'b00, F_MULH = 2'b01, F_MULHSU = 2'b10, F_MULHU = 2'b11;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   // Presents an op in the current cycle; returns one cycle later with valid dropped.
   task automatic issue(input logic [1:0] f3, input logic [31:0] ra, input logic [31:0] rb,
                        input logic [4:0] rd, output int issue_cyc);
      issue_cyc           = cyc;
      opcode_valid_i      = 1'b1;
      opcode_opcode_i     = {7'b0000001, 10'd0, 1'b0, f3, rd, 7'b0110011};
      opcode_rd_idx_i     = rd;
      opcode_ra_operand_i = ra;
      opcode_rb_operand_i = rb;
      #1;
      check("stall_on_accept", {31'd0, stall_o}, 32'd1);
      @(posedge clk_i);
      #1;
      opcode_valid_i = 1'b0;
   endtask

   task automatic expect_at(input int c, input logic [31:0] res, input logic [4:0] rd);
      exp_t e;
      e.cyc = c;
      e.res = res;
      e.rd  = rd;
      sb.push_back(e);
   endtask

   // Monitor: every completion cycle must match the head of the scoreboard.
   always @(negedge clk_i) begin
      if (mule_complete_o) begin
         if (sb.size() == 0) begin
            check("unexpected_complete", {31'd0, mule_complete_o}, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("complete_cycle", cyc, e.cyc);
            check("result", mule_result_o, e.res);
            check("rd_idx", {27'd0, mule_rd_idx_o}, {27'd0, e.rd});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int j;
      int waited;

      #2 rst_i = 1'b0;
      step(2);
      check("rst_stall", {31'd0, stall_o}, 32'd0);
      check("rst_complete", {31'd0, mule_complete_o}, 32'd0);
      check("rst_result", mule_result_o, 32'd0);
      check("rst_rd", {27'd0, mule_rd_idx_o}, 32'd0);
      rst_i = 1'b1;
      step(1);

      // Basic MUL latency and stall window.
      issue(F_MUL, 32'd7, 32'd6, 5'd5, k);
      expect_at(k + 17, 32'h0000002A, 5'd5);
      for (int i = 1; i <= 17; i++) begin
         check("stall_busy", {31'd0, stall_o}, 32'd1);
         step(1);
      end
      check("stall_idle_after", {31'd0, stall_o}, 32'd0);

      // Signed/unsigned corner cases.
      issue(F_MUL, 32'h80000000, 32'hFFFFFFFF, 5'd1, k);
      expect_at(k + 17, 32'h80000000, 5'd1);
      step(17);
      issue(F_MULH, 32'h80000000, 32'hFFFFFFFF, 5'd2, k);
      expect_at(k + 17, 32'h00000000, 5'd2);
      step(17);
      issue(F_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, k);
      expect_at(k + 17, 32'hFFFFFFFE, 5'd3);
      step(17);
      issue(F_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, k);
      expect_at(k + 17, 32'hFFFFFFFF, 5'd4);
      step(17);
      issue(F_MULH, 32'h00012345, 32'h00100000, 5'd6, k);
      expect_at(k + 17, 32'h00000012, 5'd6);
      step(17);

      // Early-out on a zero operand.
      issue(F_MULHU, 32'h12345678, 32'd0, 5'd7, k);
      expect_at(k + 1, 32'h00000000, 5'd7);
      check("early_stall_done", {31'd0, stall_o}, 32'd1);
      step(1);
      check("early_stall_idle", {31'd0, stall_o}, 32'd0);

      // Hold during RUN delays completion by the hold length.
      issue(F_MUL, 32'd100, 32'd200, 5'd8, k);
      expect_at(k + 20, 32'd20000, 5'd8);
      step(4);
      hold_i = 1'b1;
      step(3);
      hold_i = 1'b0;
      step(13);
      check("hold_run_idle", {31'd0, stall_o}, 32'd0);

      // Hold during DONE keeps completion asserted and stable.
      issue(F_MUL, 32'hFFFFFFFE, 32'd3, 5'd10, k);
      expect_at(k + 17, 32'hFFFFFFFA, 5'd10);
      expect_at(k + 18, 32'hFFFFFFFA, 5'd10);
      expect_at(k + 19, 32'hFFFFFFFA, 5'd10);
      step(16);
      hold_i = 1'b1;
      step(2);
      hold_i = 1'b0;
      step(1);
      check("hold_done_idle", {31'd0, stall_o}, 32'd0);

      // Flush aborts silently; a follow-up MUL still works.
      issue(F_MUL, 32'd9, 32'd9, 5'd11, k);
      step(7);
      flush_i = 1'b1;
      step(1);
      flush_i = 1'b0;
      check("flush_stall_drop", {31'd0, stall_o}, 32'd0);
      issue(F_MUL, 32'hFFFFFFFD, 32'd5, 5'd9, j);
      check("flush_reissue_cycle", j - k, 32'd9);
      expect_at(j + 17, 32'hFFFFFFF1, 5'd9);
      step(17);

      // Async reset mid-RUN: outputs clear immediately, no stale completion afterwards.
      issue(F_MUL, 32'd3, 32'd3, 5'd1, k);
      step(3);
      rst_i = 1'b0;
      #1;
      check("rst_mid_stall", {31'd0, stall_o}, 32'd0);
      check("rst_mid_complete", {31'd0, mule_complete_o}, 32'd0);
      check("rst_mid_result", mule_result_o, 32'd0);
      check("rst_mid_rd", {27'd0, mule_rd_idx_o}, 32'd0);
      step(2);
      rst_i = 1'b1;
      step(30);

      // Back-to-back issue honoring stall_o.
      issue(F_MUL, 32'd12, 32'd11, 5'd12, k);
      expect_at(k + 17, 32'd132, 5'd12);
      waited = 0;
      while (stall_o && waited < 40) begin
         step(1);
         waited++;
      end
      check("b2b_stall_bounded", {31'd0, stall_o}, 32'd0);
      issue(F_MULHU, 32'h80000000, 32'h00000004, 5'd13, j);
      expect_at(j + 17, 32'h00000002, 5'd13);
      check("b2b_spacing", j - k, 32'd18);
      step(20);

      check("scoreboard_drained", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/biriscv_mule_iter.md
Name: biriscv_mule_iter

Overview:
Iterative multi-cycle multiply unit. It produces the mule_complete / mule_result writeback pair that the execute stage consumes.
- Accepts RV32M MUL, MULH, MULHSU and MULHU from the issue slot.
- Computes the result with a shift-add datapath, one chunk of bits per cycle.
- Returns one result word with a one-cycle completion strobe.
- Stalls issue while busy.

Parameters:
BITS_PER_CYCLE, 2, multiplier bits consumed per RUN cycle; legal values 1, 2, 4. ITER = 32/BITS_PER_CYCLE.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-low (0 = reset)
opcode_valid_i  in  1  issue slot valid
opcode_opcode_i  in  32  instruction word
opcode_rd_idx_i  in  5  destination register index
opcode_ra_operand_i  in  32  rs1 value
opcode_rb_operand_i  in  32  rs2 value
hold_i  in  1  pipeline hold; freezes all state
flush_i  in  1  abort in-flight operation
stall_o  out  1  unit busy; upstream must not issue a mul
mule_complete_o  out  1  result valid strobe
mule_result_o  out  32  result word
mule_rd_idx_o  out  5  destination of result

Behaviour:
- Decode: op is accepted when opcode_valid_i=1 and opcode[6:0]=0110011, opcode[31:25]=0000001, opcode[14]=0. funct3 selects the op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU. All other instructions are ignored.
- Reset (rst_i=0, async): state=IDLE; stall_o=0; mule_complete_o=0; mule_result_o=0; mule_rd_idx_o=0; all internal registers cleared. Reset mid-RUN discards the operation with no completion.
- States: IDLE, RUN, DONE.
- IDLE:
  - Accepted op with hold_i=0 latches rd_idx, op and the operand magnitudes.
  - rs1 is signed for MUL, MULH and MULHSU.
  - rs2 is signed for MUL and MULH only.
  - The result sign is neg = sign_a XOR sign_b.
  - Next state is RUN, or DONE directly if either operand is 0 (early-out, product = 0).
- RUN:
  - Each cycle adds BITS_PER_CYCLE partial products of the |a| × |b| product into a 64-bit accumulator (unsigned).
  - A 6-bit iteration counter runs 0..ITER-1. The last iteration goes to DONE.
  - stall_o=1 throughout RUN.
- DONE:
  - Product P = neg ? -(acc) : acc, computed 64-bit two's complement.
  - mule_result_o = P[31:0] for MUL, else P[63:32].
  - mule_complete_o=1 and mule_rd_idx_o is valid.
  - With hold_i=0, DONE lasts exactly one cycle, then the unit returns to IDLE.
  - An op presented in the DONE cycle is not accepted; stall_o=1 in DONE.
- Latency: accept edge = cycle 0; RUN occupies cycles 1..ITER; mule_complete_o is high in cycle ITER+1 (17 for the default). Early-out: complete in cycle 1.
- stall_o = (state != IDLE). It is also combinationally 1 in IDLE while an op is being accepted, so a same-cycle dual issue is blocked.
- hold_i=1:
  - No state, counter or accumulator change.
  - Ops are not accepted in IDLE.
  - In DONE, mule_complete_o and mule_result_o stay asserted and stable until the first cycle with hold_i=0. After that cycle completion drops.
- flush_i=1: next state IDLE from any state, overriding hold_i. No completion is produced. mule_complete_o is forced to 0 in the flush cycle. A mul presented with flush_i=1 is not accepted.
- mule_result_o and mule_rd_idx_o keep their last DONE values when not completing. Consumers qualify them with mule_complete_o.
- Outputs are driven from flops: complete, result and rd_idx are registered on entry to DONE. stall_o is the only combinational output.

Test Plan:
- MUL rs1=7, rs2=6, rd=5, BITS_PER_CYCLE=2 -> stall_o high cycles 0..17; mule_complete_o high in cycle 17 only; result 0x0000002A; rd_idx 5.
- MUL rs1=0x80000000, rs2=0xFFFFFFFF -> result 0x80000000. MULH same operands -> 0x00000000. MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. MULHSU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> 0xFFFFFFFF.
- MULHU rs1=0x12345678, rs2=0 -> complete in cycle 1; result 0x00000000; no RUN cycles.
- hold_i=1 for 3 cycles starting in cycle 5 of RUN -> completion delayed to cycle 20. hold_i=1 during DONE for 2 cycles -> complete stays high 3 cycles, result stable.
- flush_i pulse in cycle 8 of RUN -> no completion; stall_o=0 from cycle 9. A MUL issued in cycle 9 completes in cycle 26 with a correct result.
- rst_i driven 0 mid-RUN (cycle 4) -> all outputs 0 immediately (async). After release, no stale completion ever appears. Back-to-back MULs with upstream honoring stall_o -> two completions, 18 cycles apart.
